seg_serial_shifter: RTL and testbench
=====================================

Name: seg_serial_shifter

Overview:
- Downstream display stage of the single-cycle CPU Top; consumes the packed segment pattern Top produces.
- Shifts the pattern serially to the board's off-chip seven-segment shift-register chain on SEGLED_CLK/SEGLED_DO/SEGLED_CLR/SEGLED_PEN.
- One start pulse performs one full shift-and-latch frame; a clock divider sets the serial bit rate.

Parameters:
- WIDTH, 64, number of bits shifted per frame (8 digits x 8 segments).
- DIV, 2, system-clock cycles per half-period of SEGLED_CLK; legal range 1..255.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to send data; honoured only when idle.
- data  in  WIDTH  segment pattern; bit WIDTH-1 is shifted first.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.
- SEGLED_CLK  out  1  serial shift clock; the external chain samples on its rising edge.
- SEGLED_DO  out  1  serial data.
- SEGLED_CLR  out  1  active-low clear of the external chain.
- SEGLED_PEN  out  1  latch/parallel-enable pulse to the external chain.

Behaviour:
- Reset values, asserted asynchronously:
  - state=IDLE; busy=0, done=0, SEGLED_CLK=0, SEGLED_DO=0, SEGLED_CLR=0, SEGLED_PEN=0.
  - Internal shift register, divider counter and bit counter all cleared to 0.
- First clock edge after Reset deasserts: SEGLED_CLR=1, and it stays 1 until the next Reset.
- States:
  - IDLE: outputs quiet (SEGLED_CLK=0, SEGLED_PEN=0, SEGLED_DO holds last value). On start=1, capture data into the shift register, set busy=1, bit counter=0, go to SH_LO.
  - SH_LO: SEGLED_CLK=0; SEGLED_DO = shift-register MSB. After DIV cycles go to SH_HI.
  - SH_HI: SEGLED_CLK=1; SEGLED_DO unchanged, so it is stable around the rising edge. After DIV cycles:
    - Shift the register left by 1 (zero fill) and increment the bit counter.
    - If the counter reaches WIDTH, go to LATCH; otherwise go to SH_LO.
  - LATCH: SEGLED_CLK=0, SEGLED_PEN=1 for DIV cycles, then go to IDLE.
  - On the IDLE entry edge: busy=0, done=1 for exactly one cycle, SEGLED_PEN=0.
- Timing:
  - busy rises on the edge that samples start.
  - busy stays high for exactly WIDTH*2*DIV + DIV cycles: 258 at the defaults.
  - done is asserted in the first cycle busy is low.
  - SEGLED_CLK produces exactly WIDTH rising edges per frame.
- Bit order: data[WIDTH-1] is on the first rising edge; data[0] is on the last.
- Boundary conditions:
  - start while busy: ignored; data is not re-captured and the frame is unaffected.
  - start in the same cycle done is high: state is IDLE, so it is accepted. The new frame begins on that edge and done still pulses.
  - data changing after capture: no effect on the frame in progress.
  - Reset mid-frame: immediate return to the reset values above, with SEGLED_CLR=0 so the external chain is wiped. No done pulse is generated.
  - The divider counter restarts at 0 on every state change, so phases never merge.

Test Plan:
- Reset held 3 cycles, then released, DIV=2 -> all outputs 0 during Reset; SEGLED_CLR=1 one edge after release; busy=0.
- start with data=64'h8000_0000_0000_0001 -> SEGLED_DO=1 at the 1st and 64th SEGLED_CLK rising edges and 0 at the other 62; exactly 64 rising edges; SEGLED_PEN high 2 cycles; busy high 258 cycles; done one cycle.
- data=64'hA5A5_0F0F_FFFF_0000, bench shift-register model -> 64 bits reconstructed from DO at rising edges equal the data; DO stable for the whole SH_HI phase.
- start pulsed again at cycle 100 of a frame with different data -> ignored; frame length still 258; second pattern never appears.
- Reset asserted at cycle 50 of a frame -> outputs go to reset values in the same cycle, SEGLED_CLR=0, no done; a new start after release sends a full correct frame.
- start asserted in the done cycle, DIV=1 -> second frame accepted back-to-back; busy low for only the done cycle; second frame is 130 cycles long.

Source files
------------

// File: rtl/seg_serial_shifter.sv
// Serialises a packed seven-segment pattern onto the board's external shift-register
// chain: one start pulse shifts WIDTH bits MSB-first, then pulses the latch enable.
module seg_serial_shifter #(
  parameter int WIDTH = 64,
  parameter int DIV   = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             SEGLED_CLK,
  output logic             SEGLED_DO,
  output logic             SEGLED_CLR,
  output logic             SEGLED_PEN
);

  localparam int CW = 8;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SH_LO, SH_HI, LATCH} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shl;
  logic             seg_do;
  logic             done_r;
  logic             clr_r;
  logic             phase_end;
  logic             last_bit;

  assign phase_end = (div_cnt == CW'(DIV - 1));
  assign last_bit  = (bit_cnt == BW'(WIDTH - 1));
  assign shreg_shl = shreg << 1;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = SH_LO;
      SH_LO:   if (phase_end) state_nxt = SH_HI;
      SH_HI:   if (phase_end) state_nxt = last_bit ? LATCH : SH_LO;
      LATCH:   if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // DO is loaded on entry to SH_LO so it is already settled a full phase before the
  // rising SEGLED_CLK edge and is held through the whole high phase.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      seg_do  <= 1'b0;
      done_r  <= 1'b0;
      clr_r   <= 1'b0;
    end else begin
      clr_r  <= 1'b1;
      done_r <= (state == LATCH) && phase_end;

      if ((state_nxt != state) || (state == IDLE)) div_cnt <= '0;
      else                                           div_cnt <= div_cnt + CW'(1);

      if ((state == IDLE) && start) begin
        shreg   <= data;
        bit_cnt <= '0;
        seg_do  <= data[WIDTH-1];
      end else if ((state == SH_HI) && phase_end) begin
        shreg   <= shreg_shl;
        bit_cnt <= bit_cnt + BW'(1);
        if (!last_bit) seg_do <= shreg_shl[WIDTH-1];
      end
    end
  end

  assign busy       = (state != IDLE);
  assign done       = done_r;
  assign SEGLED_CLK = (state == SH_HI);
  assign SEGLED_PEN = (state == LATCH);
  assign SEGLED_DO  = seg_do;
  assign SEGLED_CLR = clr_r;

endmodule

// File: tb/tb_seg_serial_shifter.sv
// Directed bench for seg_serial_shifter: a DIV=2 instance for framing, bit order,
// restart and reset cases, and a DIV=1 instance for back-to-back frames.
module tb_seg_serial_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [63:0] data0 = '0, data1 = '0;
  logic        busy0, done0, sclk0, sdo0, sclr0, spen0;
  logic        busy1, done1, sclk1, sdo1, sclr1, spen1;
  logic        sel = 1'b0;
  logic        o_busy, o_done, o_clk, o_do, o_pen;

  int compared   = 0;
  int mismatched = 0;

  int          busy_cnt, rises, pen_cnt, unstable, done_in_busy;
  logic [63:0] rec;
  logic        timed_out, aborted, done_first;

  seg_serial_shifter #(.WIDTH(64), .DIV(2)) u_dut0 (
    .CLK(clk), .Reset(rst), .start(start0), .data(data0),
    .busy(busy0), .done(done0), .SEGLED_CLK(sclk0), .SEGLED_DO(sdo0),
    .SEGLED_CLR(sclr0), .SEGLED_PEN(spen0)
  );

  seg_serial_shifter #(.WIDTH(64), .DIV(1)) u_dut1 (
    .CLK(clk), .Reset(rst), .start(start1), .data(data1),
    .busy(busy1), .done(done1), .SEGLED_CLK(sclk1), .SEGLED_DO(sdo1),
    .SEGLED_CLR(sclr1), .SEGLED_PEN(spen1)
  );

  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_clk  = sel ? sclk1 : sclk0;
  assign o_do   = sel ? sdo1  : sdo0;
  assign o_pen  = sel ? spen1 : spen0;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start1 = v;
    else   start0 = v;
  endtask

  task automatic set_data(input bit s, input logic [63:0] d);
    if (s) data1 = d;
    else   data0 = d;
  endtask

  task automatic kick(input bit s, input logic [63:0] d);
    sel = s;
    set_data(s, d);
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
  endtask

  // Walks a frame one system cycle at a time, sampling at the falling edge.
  task automatic collect(input bit s, input int inj_at, input logic [63:0] d2, input int rst_at);
    int   cyc;
    logic prev_clk, do_at_rise;
    busy_cnt = 0; rises = 0; pen_cnt = 0; unstable = 0; done_in_busy = 0;
    rec = '0; aborted = 1'b0; done_first = 1'b0;
    prev_clk = 1'b0; do_at_rise = 1'b0;
    for (cyc = 0; cyc < 1000; cyc++) begin
      if (!o_busy) break;
      busy_cnt++;
      if (o_clk && !prev_clk) begin
        rises++;
        rec = {rec[62:0], o_do};
        do_at_rise = o_do;
      end else if (o_clk && (o_do !== do_at_rise)) begin
        unstable++;
      end
      prev_clk = o_clk;
      if (o_pen)  pen_cnt++;
      if (o_done) done_in_busy++;
      set_start(s, 1'b0);
      if (cyc == inj_at) begin
        set_start(s, 1'b1);
        set_data(s, d2);
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    timed_out = (cyc >= 1000);
    if (!aborted) done_first = o_done;
  endtask

  initial begin
    int dcount;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy0, done0, sclk0, sdo0, sclr0, spen0}), 64'd0);
    chk("reset_outputs_div1", 64'({busy1, done1, sclk1, sdo1, sclr1, spen1}), 64'd0);
    rst = 1'b0;
    #1;
    chk("clr_before_first_edge", 64'(sclr0), 64'd0);
    @(negedge clk);
    chk("clr_after_release", 64'(sclr0), 64'd1);
    chk("busy_after_release", 64'(busy0), 64'd0);
    chk("pen_idle", 64'(spen0), 64'd0);

    // Frame A: only first and last bits set
    kick(1'b0, 64'h8000_0000_0000_0001);
    collect(1'b0, -1, '0, -1);
    chk("A_timeout", 64'(timed_out), 64'd0);
    chk("A_busy_cycles", 64'(busy_cnt), 64'd258);
    chk("A_clk_rises", 64'(rises), 64'd64);
    chk("A_bits", rec, 64'h8000_0000_0000_0001);
    chk("A_pen_cycles", 64'(pen_cnt), 64'd2);
    chk("A_done_first_idle", 64'(done_first), 64'd1);
    chk("A_done_during_busy", 64'(done_in_busy), 64'd0);
    @(negedge clk);
    chk("A_done_one_cycle", 64'(done0), 64'd0);
    chk("A_pen_after", 64'(spen0), 64'd0);

    // Frame B: mixed pattern, DO stable while SEGLED_CLK high
    kick(1'b0, 64'hA5A5_0F0F_FFFF_0000);
    collect(1'b0, -1, '0, -1);
    chk("B_bits", rec, 64'hA5A5_0F0F_FFFF_0000);
    chk("B_clk_rises", 64'(rises), 64'd64);
    chk("B_do_stable_high", 64'(unstable), 64'd0);
    chk("B_busy_cycles", 64'(busy_cnt), 64'd258);

    // Frame C: start re-pulsed with new data at cycle 100 is ignored
    @(negedge clk);
    kick(1'b0, 64'h0123_4567_89AB_CDEF);
    collect(1'b0, 100, 64'hFEDC_BA98_7654_3210, -1);
    chk("C_busy_cycles", 64'(busy_cnt), 64'd258);
    chk("C_bits", rec, 64'h0123_4567_89AB_CDEF);
    chk("C_done", 64'(done_first), 64'd1);
    @(negedge clk);
    chk("C_no_second_frame", 64'(busy0), 64'd0);

    // Reset at cycle 50 of an all-ones frame (SEGLED_CLK and DO both high then)
    @(negedge clk);
    kick(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    collect(1'b0, -1, '0, 50);
    chk("R_aborted", 64'(aborted), 64'd1);
    chk("R_outputs_immediate", 64'({busy0, done0, sclk0, sdo0, sclr0, spen0}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    chk("R_no_done", 64'(dcount), 64'd0);
    chk("R_busy_idle", 64'(busy0), 64'd0);
    chk("R_clr_restored", 64'(sclr0), 64'd1);

    // Frame D: full frame after the mid-frame reset
    kick(1'b0, 64'h3C3C_C3C3_5A5A_0FF0);
    collect(1'b0, -1, '0, -1);
    chk("D_bits", rec, 64'h3C3C_C3C3_5A5A_0FF0);
    chk("D_busy_cycles", 64'(busy_cnt), 64'd258);
    chk("D_done", 64'(done_first), 64'd1);

    // DIV=1: second start issued in the done cycle
    @(negedge clk);
    kick(1'b1, 64'hDEAD_BEEF_0000_FFFF);
    collect(1'b1, -1, '0, -1);
    chk("E1_busy_cycles", 64'(busy_cnt), 64'd129);
    chk("E1_bits", rec, 64'hDEAD_BEEF_0000_FFFF);
    chk("E1_pen_cycles", 64'(pen_cnt), 64'd1);
    chk("E1_done", 64'(done_first), 64'd1);
    set_data(1'b1, 64'h1357_9BDF_2468_ACE0);
    set_start(1'b1, 1'b1);
    @(negedge clk);
    set_start(1'b1, 1'b0);
    chk("E2_busy_back_to_back", 64'(busy1), 64'd1);
    collect(1'b1, -1, '0, -1);
    chk("E2_frame_len_incl_done", 64'(busy_cnt + 1), 64'd130);
    chk("E2_bits", rec, 64'h1357_9BDF_2468_ACE0);
    chk("E2_clk_rises", 64'(rises), 64'd64);
    chk("E2_done", 64'(done_first), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
